seq_arb: RTL

SEQ_ARB -- requirements
Module: seq_arb

---
 rtl/seq_pkg.sv | 22 ++
 rtl/seq_rr_arb.sv | 33 +++
 rtl/seq_arb.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared constants for the sequence arbiter and the downstream sequence detector:
// FSM encodings, the flush symbol, the detector pattern and the requester-ID width helper.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FLUSH = 2'd2
  } arb_state_e;

  localparam int FLUSH_SYM = 0;
  localparam int GAP_W     = 8;

  // Pattern recognised by the detector, oldest symbol first.
  localparam int DET_LEN = 5;
  localparam int DET_PATTERN [DET_LEN] = '{1, 2, 1, 3, 1};

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_rr_arb.sv
// Round-robin selector: searches the request vector starting at the priority pointer
// and returns the first hit as both a one-hot grant and an index.
module seq_rr_arb
  import seq_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o
);

  int   cand;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/seq_arb.sv
// Frame-level arbiter feeding a shared sequence detector: one owner streams symbols at a time,
// and each detector match is attributed back to the requester whose symbols produced it.
module seq_arb
  import seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_GAP    = 7
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_symbol,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [DATA_WIDTH-1:0]           det_symbol,
  input  logic                            det_match,
  output logic                            match_valid,
  output logic [id_width(NUM_REQ)-1:0]    match_id,
  output logic                            timeout,
  output logic                            busy
);

  localparam int ID_W = id_width(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [ID_W-1:0]        owner_q, owner_d;
  logic [NUM_REQ-1:0]     owner_oh_q, owner_oh_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [DATA_WIDTH-1:0]  sym_q, sym_d;
  logic                   tag1_valid_q, tag1_valid_d;
  logic [ID_W-1:0]        tag1_id_q, tag1_id_d;
  logic                   tag2_valid_q;
  logic [ID_W-1:0]        tag2_id_q;
  logic                   timeout_q, timeout_d;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [ID_W-1:0]        arb_idx;
  logic                   xfer;
  logic                   owner_last;
  logic [DATA_WIDTH-1:0]  owner_sym;

  seq_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign req_ready  = (state_q == GRANT) ? owner_oh_q : '0;
  assign xfer       = |(req_valid & req_ready);
  assign owner_last = req_last[owner_q];
  assign owner_sym  = req_symbol[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];

  // Every non-transfer cycle pushes FLUSH_SYM so the detector never stitches symbols across gaps or frames.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    owner_oh_d   = owner_oh_q;
    ptr_d        = ptr_q;
    gap_d        = gap_q;
    sym_d        = DATA_WIDTH'(FLUSH_SYM);
    tag1_valid_d = 1'b0;
    tag1_id_d    = owner_q;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d    = GRANT;
          owner_d    = arb_idx;
          owner_oh_d = arb_gnt;
          ptr_d      = ID_W'((int'(arb_idx) + 1) % NUM_REQ);
          gap_d      = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          sym_d        = owner_sym;
          tag1_valid_d = 1'b1;
          gap_d        = '0;
          if (owner_last) state_d = FLUSH;
        end else begin
          gap_d = gap_q + 1'b1;
          if (gap_d == GAP_W'(MAX_GAP)) begin
            state_d   = FLUSH;
            timeout_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The second tag stage lines up with the detector's registered match output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      owner_oh_q   <= '0;
      ptr_q        <= '0;
      gap_q        <= '0;
      sym_q        <= DATA_WIDTH'(FLUSH_SYM);
      tag1_valid_q <= 1'b0;
      tag1_id_q    <= '0;
      tag2_valid_q <= 1'b0;
      tag2_id_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      owner_oh_q   <= owner_oh_d;
      ptr_q        <= ptr_d;
      gap_q        <= gap_d;
      sym_q        <= sym_d;
      tag1_valid_q <= tag1_valid_d;
      tag1_id_q    <= tag1_id_d;
      tag2_valid_q <= tag1_valid_q;
      tag2_id_q    <= tag1_id_q;
      timeout_q    <= timeout_d;
    end
  end

  assign det_symbol  = sym_q;
  assign match_valid = det_match & tag2_valid_q;
  assign match_id    = tag2_id_q;
  assign timeout     = timeout_q;
  assign busy        = (state_q != IDLE);

endmodule
